// File: rtl/pattern_sequencer.sv
// Programmable step sequencer feeding the notes ROM.
// A DEPTH-entry pattern of note indices (0 = rest) is stepped through on each
// tempo strobe. Each step load drives the note index, a gate for the envelope
// generator and a one-cycle note-start pulse for every non-rest step.
//
// Interface semantics: strb_i is a one-cycle pulse and is acted on only in
// PLAY; wr_en_i is a fire-and-forget write, always accepted with no back
// pressure in any state. play_i and loop_i are levels sampled on every edge.
// All outputs are registered. state_o exposes the FSM state for debug.
module pattern_sequencer #(
   parameter int IDX_W  = 6,
   parameter int ADDR_W = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              strb_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [IDX_W-1:0]  wr_data_i,
   input  logic              play_i,
   input  logic              loop_i,
   input  logic [ADDR_W-1:0] len_i,
   output logic [IDX_W-1:0]  noteIndex_o,
   output logic              note_on_o,
   output logic              gate_o,
   output logic [ADDR_W-1:0] step_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [1:0]        state_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   mem [DEPTH];
   logic [ADDR_W-1:0]  next_step;
   logic [IDX_W-1:0]   next_note;
   logic               at_end;

   // Address of the step a strobe would load: advance, or wrap to 0 at/after
   // the last step (>= so a shrinking len_i wraps at the next strobe).
   always_comb begin
      at_end    = (step_o >= len_i);
      next_step = at_end ? '0 : step_o + ADDR_W'(1);
      next_note = mem[next_step];
   end

   assign state_o = state;

   // Sequencer FSM, pattern memory and all registered outputs. Memory reads
   // here see the pre-write contents, giving read-before-write on collisions.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         noteIndex_o <= '0;
         note_on_o   <= 1'b0;
         gate_o      <= 1'b0;
         step_o      <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         note_on_o <= 1'b0;
         done_o    <= 1'b0;

         if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
         end

         case (state)
            IDLE: begin
               if (play_i) begin
                  state       <= PLAY;
                  busy_o      <= 1'b1;
                  step_o      <= '0;
                  noteIndex_o <= mem[0];
                  gate_o      <= (mem[0] != '0);
                  note_on_o   <= (mem[0] != '0);
               end else begin
                  noteIndex_o <= '0;
                  gate_o      <= 1'b0;
                  busy_o      <= 1'b0;
                  step_o      <= '0;
               end
            end

            PLAY: begin
               if (!play_i) begin
                  // Stop wins over a simultaneous strobe; no done pulse.
                  state       <= IDLE;
                  noteIndex_o <= '0;
                  gate_o      <= 1'b0;
                  step_o      <= '0;
                  busy_o      <= 1'b0;
               end else if (strb_i) begin
                  if (!at_end || loop_i) begin
                     step_o      <= next_step;
                     noteIndex_o <= next_note;
                     gate_o      <= (next_note != '0);
                     note_on_o   <= (next_note != '0);
                  end else begin
                     state       <= DONE;
                     done_o      <= 1'b1;
                     noteIndex_o <= '0;
                     gate_o      <= 1'b0;
                     busy_o      <= 1'b0;
                     step_o      <= '0;
                  end
               end
            end

            DONE: begin
               // Hold until play_i drops so a held play_i cannot restart.
               noteIndex_o <= '0;
               gate_o      <= 1'b0;
               busy_o      <= 1'b0;
               step_o      <= '0;
               if (!play_i) begin
                  state <= IDLE;
               end
            end

            default: begin
               state       <= IDLE;
               noteIndex_o <= '0;
               gate_o      <= 1'b0;
               busy_o      <= 1'b0;
               step_o      <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed testbench for pattern_sequencer with hand-computed expectations.
module tb_pattern_sequencer;

   localparam int IDX_W  = 6;
   localparam int ADDR_W = 5;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PLAY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              strb_i;
   logic              wr_en_i;
   logic [ADDR_W-1:0] wr_addr_i;
   logic [IDX_W-1:0]  wr_data_i;
   logic              play_i;
   logic              loop_i;
   logic [ADDR_W-1:0] len_i;
   logic [IDX_W-1:0]  noteIndex_o;
   logic              note_on_o;
   logic              gate_o;
   logic [ADDR_W-1:0] step_o;
   logic              busy_o;
   logic              done_o;
   logic [1:0]        state_o;

   int n_cmp = 0;
   int n_err = 0;

   pattern_sequencer #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .strb_i      (strb_i),
      .wr_en_i     (wr_en_i),
      .wr_addr_i   (wr_addr_i),
      .wr_data_i   (wr_data_i),
      .play_i      (play_i),
      .loop_i      (loop_i),
      .len_i       (len_i),
      .noteIndex_o (noteIndex_o),
      .note_on_o   (note_on_o),
      .gate_o      (gate_o),
      .step_o      (step_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .state_o     (state_o)
   );

   // Clock and reset block
   always #5 clk_i = ~clk_i;

   // Single checker: counts and reports.
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one edge; sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic write_mem(input logic [ADDR_W-1:0] a, input logic [IDX_W-1:0] d);
      wr_en_i   = 1'b1;
      wr_addr_i = a;
      wr_data_i = d;
      tick();
      wr_en_i   = 1'b0;
   endtask

   task automatic strobe();
      strb_i = 1'b1;
      tick();
      strb_i = 1'b0;
   endtask

   task automatic expect_step(input string tag, input int step, input int note, input logic on);
      check_val({tag, ".step"}, 32'(step_o), 32'(step));
      check_val({tag, ".note"}, 32'(noteIndex_o), 32'(note));
      check_val({tag, ".note_on"}, 32'(note_on_o), 32'(on));
      check_val({tag, ".gate"}, 32'(gate_o), 32'(note != 0));
      check_val({tag, ".busy"}, 32'(busy_o), 32'd1);
      check_val({tag, ".done"}, 32'(done_o), 32'd0);
   endtask

   task automatic expect_idle(input string tag);
      check_val({tag, ".state"}, 32'(state_o), 32'(S_IDLE));
      check_val({tag, ".note"}, 32'(noteIndex_o), 32'd0);
      check_val({tag, ".gate"}, 32'(gate_o), 32'd0);
      check_val({tag, ".busy"}, 32'(busy_o), 32'd0);
      check_val({tag, ".step"}, 32'(step_o), 32'd0);
      check_val({tag, ".done"}, 32'(done_o), 32'd0);
      check_val({tag, ".note_on"}, 32'(note_on_o), 32'd0);
   endtask

   initial begin
      rst_i = 1'b1; strb_i = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
      play_i = 1'b0; loop_i = 1'b0; len_i = '0;
      tick(); tick();
      rst_i = 1'b0;
      expect_idle("reset");

      // One-shot pattern {5,7,0,9}
      write_mem(0, 5); write_mem(1, 7); write_mem(2, 0); write_mem(3, 9);
      len_i = 3; loop_i = 1'b0; play_i = 1'b1;
      tick();
      check_val("os.state", 32'(state_o), 32'(S_PLAY));
      expect_step("os0", 0, 5, 1'b1);
      tick();
      expect_step("os0hold", 0, 5, 1'b0);
      strobe(); expect_step("os1", 1, 7, 1'b1);
      strobe(); expect_step("os2", 2, 0, 1'b0);
      strobe(); expect_step("os3", 3, 9, 1'b1);
      strobe();
      check_val("os.done", 32'(done_o), 32'd1);
      check_val("os.done_note", 32'(noteIndex_o), 32'd0);
      check_val("os.done_gate", 32'(gate_o), 32'd0);
      check_val("os.done_busy", 32'(busy_o), 32'd0);
      check_val("os.done_state", 32'(state_o), 32'(S_DONE));
      tick();
      check_val("os.done_pulse", 32'(done_o), 32'd0);
      check_val("os.done_hold", 32'(state_o), 32'(S_DONE));
      play_i = 1'b0;
      tick();
      expect_idle("os.idle");

      // Looping pattern
      loop_i = 1'b1; play_i = 1'b1;
      tick(); expect_step("lp0", 0, 5, 1'b1);
      strobe(); strobe(); strobe(); expect_step("lp3", 3, 9, 1'b1);
      strobe(); expect_step("lpwrap", 0, 5, 1'b1);
      play_i = 1'b0; tick(); expect_idle("lp.idle");

      // Repeated identical note still pulses note_on
      write_mem(0, 12); write_mem(1, 12);
      len_i = 1; play_i = 1'b1;
      tick(); expect_step("rp0", 0, 12, 1'b1);
      tick(); expect_step("rp0hold", 0, 12, 1'b0);
      strobe(); expect_step("rp1", 1, 12, 1'b1);
      strobe(); expect_step("rp0b", 0, 12, 1'b1);
      play_i = 1'b0; tick(); expect_idle("rp.idle");

      // Read-before-write on a colliding step load; pattern {12,12,0,9}
      len_i = 3; play_i = 1'b1;
      tick(); expect_step("rbw0", 0, 12, 1'b1);
      strobe(); expect_step("rbw1", 1, 12, 1'b1);
      strb_i = 1'b1; wr_en_i = 1'b1; wr_addr_i = 2; wr_data_i = 20;
      tick();
      strb_i = 1'b0; wr_en_i = 1'b0;
      expect_step("rbw2old", 2, 0, 1'b0);
      strobe(); expect_step("rbw3", 3, 9, 1'b1);
      strobe(); expect_step("rbw0b", 0, 12, 1'b1);
      strobe(); expect_step("rbw1b", 1, 12, 1'b1);
      strobe(); expect_step("rbw2new", 2, 20, 1'b1);

      // Stop beats a simultaneous strobe at step 2
      play_i = 1'b0; strb_i = 1'b1;
      tick();
      strb_i = 1'b0;
      expect_idle("stop");
      play_i = 1'b1;
      tick(); expect_step("restart", 0, 12, 1'b1);

      // Reset mid-play at step 3 clears memory
      strobe(); strobe(); strobe(); expect_step("prerst", 3, 9, 1'b1);
      rst_i = 1'b1;
      tick();
      expect_idle("midrst");
      rst_i = 1'b0;
      tick();
      check_val("postrst.state", 32'(state_o), 32'(S_PLAY));
      expect_step("postrst0", 0, 0, 1'b0);
      strobe(); expect_step("postrst1", 1, 0, 1'b0);
      strobe(); expect_step("postrst2", 2, 0, 1'b0);

      // len_i = 0 one-shot ends after a single step
      play_i = 1'b0; tick();
      write_mem(0, 3);
      len_i = 0; loop_i = 1'b0; play_i = 1'b1;
      tick(); expect_step("len0", 0, 3, 1'b1);
      strobe();
      check_val("len0.done", 32'(done_o), 32'd1);
      check_val("len0.state", 32'(state_o), 32'(S_DONE));
      check_val("len0.note", 32'(noteIndex_o), 32'd0);

      // strb_i ignored in IDLE
      play_i = 1'b0; tick();
      strobe();
      expect_idle("idle_strb");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
- Programmable step sequencer that replaces the fixed sequence counter ahead of the notes ROM.
- Holds a writable pattern of note indices. Steps through it on each tempo strobe from the strobe generator.
- Drives the note index into the notes ROM, plus a clean note-start pulse and a gate for the envelope generator.
- Pattern is loaded through a simple write port, intended to be driven from uio_in/ui_in decoding at top level.

Parameters:
- IDX_W, 6, width of a note index; index 0 = rest.
- ADDR_W, 5, pattern address width; DEPTH = 2**ADDR_W = 32 steps.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- strb_i  in  1  step strobe, 1-cycle pulse from the strobe generator
- wr_en_i  in  1  pattern write enable
- wr_addr_i  in  ADDR_W  pattern write address
- wr_data_i  in  IDX_W  note index to write
- play_i  in  1  level; 1 = run, 0 = stop
- loop_i  in  1  1 = wrap at end of pattern, 0 = one-shot
- len_i  in  ADDR_W  index of last step played (pattern length minus 1)
- noteIndex_o  out  IDX_W  current note index to the notes ROM
- note_on_o  out  1  1-cycle pulse when a non-rest step starts
- gate_o  out  1  high while the current step is a non-rest note
- step_o  out  ADDR_W  current step address
- busy_o  out  1  high in PLAY
- done_o  out  1  1-cycle pulse when a one-shot pattern ends

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset (rst_i=1 at a rising edge), which overrides every other input:
  - state=IDLE; all pattern entries = 0.
  - noteIndex_o=0, step_o=0; note_on_o, gate_o, busy_o, done_o = 0.
  - Reset asserted mid-play aborts the pattern immediately; no done_o pulse.
- Pattern memory:
  - DEPTH x IDX_W flops.
  - On a rising edge with wr_en_i=1, mem[wr_addr_i] <= wr_data_i. Writes are accepted in every state.
  - Read-before-write: a step load in the same cycle as a write to the same address loads the OLD value. The new value is used on the next visit.
- All outputs are registered. noteIndex_o is latched at step load and does not follow later writes.
- States: IDLE, PLAY, DONE.
- IDLE:
  - Outputs noteIndex_o=0, gate_o=0, busy_o=0.
  - play_i=1 -> PLAY, with a step load of address 0 on that edge. strb_i is ignored in IDLE.
- Step load of address A (registered at one edge):
  - step_o=A, noteIndex_o=mem[A].
  - gate_o = (mem[A]!=0).
  - note_on_o=1 for exactly one cycle only if mem[A]!=0, including a repeat of the same note.
- PLAY, evaluated in priority order:
  - play_i=0 -> IDLE next edge: noteIndex_o=0, gate_o=0, step_o=0, no done_o. This wins over a simultaneous strb_i.
  - strb_i=1 and step_o < len_i -> step load of step_o+1.
  - strb_i=1 and step_o >= len_i, loop_i=1 -> step load of 0. Using >= means a shrinking len_i below the current step wraps at the next strobe.
  - strb_i=1 and step_o >= len_i, loop_i=0 -> DONE: done_o=1 for one cycle, noteIndex_o=0, gate_o=0, busy_o=0.
  - len_i=0 -> step 0 repeats, or ends after one step in one-shot mode.
- DONE:
  - Outputs as IDLE.
  - Stays in DONE until play_i=0, then -> IDLE. This prevents an automatic restart while play_i is held high.
- Latency:
  - play_i rise -> first note visible 1 cycle later.
  - strb_i -> new step visible 1 cycle later.
- Widths:
  - step increment is ADDR_W wide and never overflows, since it is bounded by len_i <= DEPTH-1.
  - noteIndex_o feeds the ROM directly, with no remapping.

Test Plan:
- Reset then write mem[0..3]={5,7,0,9}, len_i=3, loop_i=0, play_i=1 -> one cycle later noteIndex_o=5, note_on_o pulse. Each strb_i advances 7, 0 (gate_o=0, no note_on_o), 9. Next strb_i -> done_o pulse, noteIndex_o=0, state DONE. play_i low -> IDLE.
- Same pattern, loop_i=1 -> after step 3 a strb_i loads step 0 (noteIndex_o=5, note_on_o pulse); busy_o stays 1 and done_o never fires.
- mem[0]=mem[1]=12, len_i=1, loop -> note_on_o pulses on every strobe despite the identical index.
- During PLAY at step 1, write mem[2]=20 in the same cycle as the strb_i that loads step 2 -> noteIndex_o = old mem[2]. The next loop visit shows 20.
- play_i=0 and strb_i=1 in the same cycle at step 2 -> IDLE, noteIndex_o=0, no done_o. Reasserting play_i restarts at step 0.
- rst_i pulsed mid-play at step 3 -> all outputs 0, memory cleared. A subsequent play_i gives noteIndex_o=0 with no note_on_o.
